piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out shifter; next generation of the fixed 8-bit PISO primitive.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled cycle.
- Bit order is selectable. Output carries a valid flag and a last-bit marker.
- Sits between a parallel datapath and serial links (SPI/UART-style TX front ends) in the mantle ice40 library.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_shift_reg.sv | 48 ++++
 rtl/piso_serializer.sv | 102 ++++++++++
 tb/tb_piso_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Holds the FSM state encoding and the bit-counter width helper.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must reach WIDTH when the parity bit is appended.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Shift register with parallel load, shifting toward the serial output end.
// Ports: clk_i, rst_ni (async low), load_i, shift_i, d_i[WIDTH], ser_o.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             ser_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] shifted;

    // Vacated bit at the far end fills with zero.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sreg_q[WIDTH-2:0], 1'b0};
            assign ser_o   = sreg_q[WIDTH-1];
        end else begin : g_lsb
            assign shifted = {1'b0, sreg_q[WIDTH-1:1]};
            assign ser_o   = sreg_q[0];
        end
    endgenerate

    // Two-level mux: load has priority over shift, otherwise hold.
    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = d_i;
        end else if (shift_i) begin
            sreg_d = shifted;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer with valid/ready input and valid/last output.
// Ports: CLK, ASYNCRESETN, PI, PI_VALID, PI_READY, CE, O, O_VALID, LAST.
// Optional macro PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] PI,
    input  logic             PI_VALID,
    output logic             PI_READY,
    input  logic             CE,
    output logic             O,
    output logic             O_VALID,
    output logic             LAST
);

    localparam int CW = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic in_shift;
    logic last_bit;
    logic accept;
    logic advance;
    logic data_bit;

    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift && (cnt_q == LAST_CNT);
    assign PI_READY = (state_q == IDLE) || (last_bit && CE);
    assign accept   = PI_VALID && PI_READY;
    assign advance  = in_shift && CE && !last_bit;

    piso_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sreg (
        .clk_i  (CLK),
        .rst_ni (ASYNCRESETN),
        .load_i (accept),
        .shift_i(advance),
        .d_i    (PI),
        .ser_o  (data_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
        end else if (advance) begin
            cnt_d = cnt_q + CW'(1);
        end else if (last_bit && CE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PISO_PARITY_EN
    logic parity_q;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^PI;
        end
    end

    // Count WIDTH is the slot after all data bits: emit parity there.
    assign O = (cnt_q == CW'(WIDTH)) ? parity_q : data_bit;
`else
    assign O = data_bit;
`endif

    assign O_VALID = in_shift;
    assign LAST    = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench: MSB- and LSB-first instances share inputs.
// Covers reset, bit order, back-to-back frames, CE stalls, parity, reset abort.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] pi;
    logic       pi_valid;
    logic       ce;
    logic       rdy_m, o_m, ov_m, last_m;
    logic       rdy_l, o_l, ov_l, last_l;

    int n_cmp;
    int n_err;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .ASYNCRESETN(rst_n), .PI(pi), .PI_VALID(pi_valid),
        .PI_READY(rdy_m), .CE(ce), .O(o_m), .O_VALID(ov_m), .LAST(last_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .ASYNCRESETN(rst_n), .PI(pi), .PI_VALID(pi_valid),
        .PI_READY(rdy_l), .CE(ce), .O(o_l), .O_VALID(ov_l), .LAST(last_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected serial bit b of a frame carrying word w.
    function automatic logic eb(input logic [7:0] w, input int b, input bit msb);
        if (b >= 8) return ^w;
        return msb ? w[7-b] : w[b];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pi = 8'($urandom);
            pi_valid = 1'($urandom);
            ce = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({o_m, ov_m, last_m, rdy_m, o_l, ov_l, last_l, rdy_l} !== 8'b0001_0001) begin
                n_err++;
                $display("FAIL reset_hold: got %b expected 00010001",
                         {o_m, ov_m, last_m, rdy_m, o_l, ov_l, last_l, rdy_l});
            end
        end
        pi_valid = 1'b0;
        ce = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ov_m, last_m, rdy_m, ov_l, last_l, rdy_l} !== 6'b001_001) begin
            n_err++;
            $display("FAIL reset_idle: got %b expected 001001",
                     {ov_m, last_m, rdy_m, ov_l, last_l, rdy_l});
        end
    endtask

    // Sends one word and checks every serial slot; optional 3-cycle CE stall.
    task automatic run_frame(input logic [7:0] w, input string nm, input int stall_at);
        int b;
        int stalls;
        @(negedge clk);
        pi = w;
        pi_valid = 1'b1;
        ce = 1'b1;
        @(negedge clk);
        pi_valid = 1'b0;
        b = 0;
        stalls = 0;
        while (b < FRAME) begin
            n_cmp++;
            if (ov_m !== 1'b1 || ov_l !== 1'b1
                || o_m !== eb(w, b, 1'b1) || o_l !== eb(w, b, 1'b0)
                || last_m !== (b == FRAME-1) || last_l !== (b == FRAME-1)) begin
                n_err++;
                $display("FAIL %s bit%0d: got v=%b%b o=%b%b last=%b%b expected v=11 o=%b%b last=%b",
                         nm, b, ov_m, ov_l, o_m, o_l, last_m, last_l,
                         eb(w, b, 1'b1), eb(w, b, 1'b0), (b == FRAME-1));
            end
            if (b == stall_at && stalls < 3) begin
                ce = 1'b0;
                stalls++;
            end else begin
                ce = 1'b1;
            end
            #1;
            n_cmp++;
            if (rdy_m !== (b == FRAME-1 && ce) || rdy_l !== (b == FRAME-1 && ce)) begin
                n_err++;
                $display("FAIL %s ready%0d: got %b%b expected %b",
                         nm, b, rdy_m, rdy_l, (b == FRAME-1 && ce));
            end
            if (ce) b++;
            @(negedge clk);
        end
        n_cmp++;
        if (ov_m !== 1'b0 || ov_l !== 1'b0 || rdy_m !== 1'b1) begin
            n_err++;
            $display("FAIL %s end: got valid=%b%b ready=%b expected valid=00 ready=1",
                     nm, ov_m, ov_l, rdy_m);
        end
    endtask

    task automatic test_msb_first();
        run_frame(8'hA5, "a5", -1);
    endtask

    task automatic test_lsb_first();
        run_frame(8'h01, "x01", -1);
    endtask

    task automatic test_ce_stall();
        run_frame(8'hC3, "stall", 3);
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        int b;
        @(negedge clk);
        pi = 8'hF0;
        pi_valid = 1'b1;
        ce = 1'b1;
        @(negedge clk);
        pi = 8'h0F;
        for (int k = 0; k < 2*FRAME; k++) begin
            w = (k < FRAME) ? 8'hF0 : 8'h0F;
            b = k % FRAME;
            if (k == FRAME) pi_valid = 1'b0;
            #1;
            n_cmp++;
            if (ov_m !== 1'b1 || o_m !== eb(w, b, 1'b1) || o_l !== eb(w, b, 1'b0)
                || last_m !== (b == FRAME-1) || rdy_m !== (b == FRAME-1)) begin
                n_err++;
                $display("FAIL b2b slot%0d: got v=%b o=%b%b last=%b rdy=%b expected v=1 o=%b%b last=%b rdy=%b",
                         k, ov_m, o_m, o_l, last_m, rdy_m, eb(w, b, 1'b1),
                         eb(w, b, 1'b0), (b == FRAME-1), (b == FRAME-1));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ov_m !== 1'b0 || ov_l !== 1'b0) begin
            n_err++;
            $display("FAIL b2b end: got valid=%b%b expected 00", ov_m, ov_l);
        end
    endtask

    task automatic test_parity_reset();
        run_frame(8'h07, "x07", -1);
        @(negedge clk);
        pi = 8'hFF;
        pi_valid = 1'b1;
        ce = 1'b1;
        @(negedge clk);
        pi_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_m, ov_m, last_m, rdy_m, o_l, ov_l, last_l, rdy_l} !== 8'b0001_0001) begin
            n_err++;
            $display("FAIL abort_reset: got %b expected 00010001",
                     {o_m, ov_m, last_m, rdy_m, o_l, ov_l, last_l, rdy_l});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ov_m !== 1'b0 || ov_l !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got valid=%b%b expected 00", ov_m, ov_l);
        end
        run_frame(8'h3C, "fresh", -1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        pi = 8'h00;
        pi_valid = 1'b0;
        ce = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_ce_stall();
        test_parity_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
